// File: rtl/i2s_sample_feeder.sv
// rtl/i2s_sample_feeder.sv - frame FIFO and playback sequencer feeding the I2S transmitter
module i2s_sample_feeder #(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int PRIME_LVL = 8,
    parameter int UCNT_W    = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [31:0]       wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic [AW:0]       level,
    input  logic              start,
    input  logic              stop,
    input  logic              i2s_bussy,
    output logic [31:0]       sample_out,
    output logic              play_en,
    output logic [UCNT_W-1:0] underrun_cnt,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRIME = 2'b01,
        RUN   = 2'b10,
        STOP  = 2'b11
    } state_t;

    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] PRIME_THR = (AW+1)'(PRIME_LVL);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          bussy_in;
    logic          s1, s2, s3;
    logic          frame_tick;
    logic          stop_pending;
    state_t        state;

    assign full    = (count == FULL_LVL);
    assign level   = count;
    assign state_o = state;
    assign push    = wr_en & ~full;

    // The transmitter's bussy is meaningless while disabled; hold it idle-high so no tick fires.
    assign bussy_in   = play_en ? i2s_bussy : 1'b1;
    assign frame_tick = s3 & ~s2;

    always_comb begin
        pop = 1'b0;
        case (state)
            PRIME:   pop = ~stop && (count >= PRIME_THR);
            RUN:     pop = frame_tick && !stop_pending && (count != '0);
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            s1     <= 1'b1;
            s2     <= 1'b1;
            s3     <= 1'b1;
        end else begin
            s1 <= bussy_in;
            s2 <= s1;
            s3 <= s2;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state        <= IDLE;
            sample_out   <= '0;
            play_en      <= 1'b0;
            underrun_cnt <= '0;
            stop_pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sample_out   <= '0;
                    play_en      <= 1'b0;
                    stop_pending <= 1'b0;
                    if (start && !stop) state <= PRIME;
                end
                PRIME: begin
                    play_en <= 1'b0;
                    if (stop) begin
                        state <= IDLE;
                    end else if (pop) begin
                        sample_out <= mem[rd_ptr];
                        play_en    <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    play_en <= 1'b1;
                    if (stop) stop_pending <= 1'b1;
                    if (frame_tick) begin
                        if (stop_pending) begin
                            sample_out   <= '0;
                            stop_pending <= 1'b0;
                            state        <= STOP;
                        end else if (count != '0) begin
                            sample_out <= mem[rd_ptr];
                        end else begin
                            sample_out <= '0;
                            if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    // One whole frame of silence goes out before the transmitter is disabled.
                    sample_out <= '0;
                    play_en    <= 1'b1;
                    if (frame_tick) begin
                        play_en <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// tb/tb_i2s_sample_feeder.sv - scoreboard bench for i2s_sample_feeder
module tb_i2s_sample_feeder;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] wr_data = '0;
    logic        wr_en = 1'b0;
    logic        full;
    logic [4:0]  level;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        i2s_bussy = 1'b1;
    logic [31:0] sample_out;
    logic        play_en;
    logic [7:0]  underrun_cnt;
    logic [1:0]  state_o;

    logic        latch = 1'b0;
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    i2s_sample_feeder #(.DEPTH(16), .AW(4), .PRIME_LVL(8), .UCNT_W(8)) dut (
        .CLK(CLK), .reset(reset), .wr_data(wr_data), .wr_en(wr_en), .full(full),
        .level(level), .start(start), .stop(stop), .i2s_bussy(i2s_bussy),
        .sample_out(sample_out), .play_en(play_en), .underrun_cnt(underrun_cnt),
        .state_o(state_o)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Models the transmitter latching iData mid-frame.
    always @(negedge CLK) begin
        if (latch && play_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL latch_unexpected: got %h expected none", sample_out);
            end else begin
                chk("latch_sample", sample_out, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge CLK) #1;
    endtask

    task automatic wr(input logic [31:0] d);
        wr_data = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    // One frame: latch point in the right half, then bussy falls to start the next frame.
    task automatic frames(input int n);
        for (int f = 0; f < n; f++) begin
            repeat (8) step();
            latch = 1'b1;
            step();
            latch = 1'b0;
            i2s_bussy = 1'b0;
            repeat (8) step();
            i2s_bussy = 1'b1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_play(input string name);
        for (int i = 0; i < 10 && !play_en; i++) step();
        chk(name, {31'd0, play_en}, 32'd1);
    endtask

    initial begin
        // reset held while driving writes and start
        wr_en = 1'b1;
        wr_data = 32'hDEAD_BEEF;
        start = 1'b1;
        repeat (3) step();
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_play_en", {31'd0, play_en}, 32'd0);
        chk("rst_sample", sample_out, 32'd0);
        chk("rst_underrun", {24'd0, underrun_cnt}, 32'd0);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        wr_en = 1'b0;
        start = 1'b0;
        reset = 1'b1;
        step();

        // fill past full; 17..20 dropped
        for (int i = 1; i <= 20; i++) begin
            wr(32'h0001_0001 * i);
            if (i == 15) chk("fill_not_full", {31'd0, full}, 32'd0);
            if (i == 16) chk("fill_full", {31'd0, full}, 32'd1);
        end
        chk("fill_level", {27'd0, level}, 32'd16);

        pulse_start();
        wait_play("prime1_play_en");
        chk("prime1_sample", sample_out, 32'h0001_0001);
        chk("prime1_level", {27'd0, level}, 32'd15);
        chk("prime1_state", {30'd0, state_o}, 32'd2);
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'h0001_0001 * i);
        frames(4);
        for (int k = 0; k < 4; k++) wr(32'hB000_B000 + k);
        chk("wrap_level", {27'd0, level}, 32'd15);
        for (int i = 5; i <= 16; i++) exp_q.push_back(32'h0001_0001 * i);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'hB000_B000 + k);
        frames(16);
        chk("drain_level", {27'd0, level}, 32'd0);
        chk("drain_underrun", {24'd0, underrun_cnt}, 32'd1);

        // underrun: silence each frame
        repeat (3) exp_q.push_back(32'd0);
        frames(3);
        chk("underrun_cnt4", {24'd0, underrun_cnt}, 32'd4);

        // stop with 5 frames queued
        for (int k = 0; k < 6; k++) wr(32'hC000_C000 + k);
        exp_q.push_back(32'd0);
        frames(1);
        chk("stop_pre_level", {27'd0, level}, 32'd5);
        stop = 1'b1;
        step();
        stop = 1'b0;
        exp_q.push_back(32'hC000_C000);
        exp_q.push_back(32'd0);
        frames(2);
        chk("stop_play_en", {31'd0, play_en}, 32'd0);
        chk("stop_level", {27'd0, level}, 32'd5);
        chk("stop_state", {30'd0, state_o}, 32'd0);
        chk("stop_underrun", {24'd0, underrun_cnt}, 32'd4);

        // prime from partial fill, then reset mid-frame
        pulse_start();
        for (int k = 0; k < 3; k++) wr(32'hD000_D000 + k);
        wait_play("prime2_play_en");
        chk("prime2_sample", sample_out, 32'hC000_C001);
        chk("prime2_level", {27'd0, level}, 32'd7);
        exp_q.push_back(32'hC000_C001);
        frames(1);
        repeat (8) step();
        i2s_bussy = 1'b0;
        repeat (6) step();
        reset = 1'b0;
        step();
        chk("midrst_play_en", {31'd0, play_en}, 32'd0);
        chk("midrst_level", {27'd0, level}, 32'd0);
        chk("midrst_state", {30'd0, state_o}, 32'd0);
        chk("midrst_sample", sample_out, 32'd0);
        chk("midrst_underrun", {24'd0, underrun_cnt}, 32'd0);
        reset = 1'b1;
        i2s_bussy = 1'b1;
        step();

        for (int k = 0; k < 8; k++) wr(32'hE000_E000 + k);
        pulse_start();
        wait_play("prime3_play_en");
        chk("prime3_sample", sample_out, 32'hE000_E000);
        for (int k = 0; k < 8; k++) exp_q.push_back(32'hE000_E000 + k);
        frames(8);
        chk("replay_underrun", {24'd0, underrun_cnt}, 32'd1);

        // saturation: 300 underrun frames in total
        repeat (253) exp_q.push_back(32'd0);
        frames(253);
        chk("sat_254", {24'd0, underrun_cnt}, 32'd254);
        repeat (47) exp_q.push_back(32'd0);
        frames(47);
        chk("sat_255", {24'd0, underrun_cnt}, 32'd255);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_sample_feeder.md
Name: i2s_sample_feeder

Overview:
Upstream stage of the I2S transmitter. It buffers 32-bit stereo frames from the system side, with left sample in [31:16] and right in [15:0], in a FIFO. It drives the transmitter's iData and enable inputs and advances one frame per I2S frame, timed by the transmitter's bussy output. It handles priming, underrun and stop so the transmitter always sees a stable word before it latches.

Parameters:
DEPTH, 16, FIFO depth in 32-bit frames; power of two, at least 4
AW, 4, address width; log2(DEPTH)
PRIME_LVL, 8, FIFO level required before playback starts; 1..DEPTH
UCNT_W, 8, width of the saturating underrun counter

Ports:
CLK  input  1  system clock, shared with the transmitter's clock input
reset  input  1  synchronous, active-low reset (0 = reset)
wr_data  input  32  frame to enqueue
wr_en  input  1  enqueue request; ignored when full=1
full  output  1  FIFO holds DEPTH entries
level  output  AW+1  current FIFO occupancy, 0..DEPTH
start  input  1  single-cycle pulse: begin playback
stop  input  1  single-cycle pulse: end playback at the next frame boundary
i2s_bussy  input  1  transmitter's bussy output
sample_out  output  32  drives transmitter iData
play_en  output  1  drives transmitter enable
underrun_cnt  output  UCNT_W  count of frames played as silence due to an empty FIFO
state_o  output  2  current state encoding, for debug

Behaviour:
- All logic runs on the rising edge of CLK. reset=0 at any clock edge forces:
  - state IDLE, FIFO empty (level=0, full=0);
  - sample_out=0, play_en=0, underrun_cnt=0;
  - synchroniser flops = 1.
- Reset mid-frame aborts immediately. No drain.
- FIFO write:
  - push when wr_en=1 and full=0; write pointer wraps modulo DEPTH.
  - wr_en while full is dropped, with no state change.
- Simultaneous push and pop: level is unchanged and both pointers advance. A push into an empty FIFO in the same cycle as a pop attempt counts as an underrun; the pushed word stays in the FIFO.
- Frame-boundary detection:
  - i2s_bussy passes through a 2-flop synchroniser (s1, s2) plus a delay flop s3.
  - frame_tick = s3 & ~s2, i.e. the falling edge of bussy (start of the left half).
  - The transmitter latches iData on the rising edge of WSelect, half a frame later, so sample_out is stable for at least 16 bit clocks before it is latched.
- States (state_o encoding):
  - IDLE (00):
    - play_en=0, sample_out=0.
    - start=1 goes to PRIME.
    - The FIFO keeps accepting writes.
  - PRIME (01):
    - play_en=0.
    - When level >= PRIME_LVL: pop the head into sample_out, set play_en=1, go to RUN, all in one cycle.
    - stop=1 goes to IDLE.
  - RUN (10):
    - play_en=1.
    - On frame_tick with level>0: pop the head into sample_out.
    - On frame_tick with level=0: sample_out=0 and underrun_cnt += 1, saturating at all-ones.
    - stop=1 sets stop_pending. On the next frame_tick, go to STOP without popping.
  - STOP (11):
    - sample_out=0 and play_en stays 1 for exactly one full frame, which flushes silence.
    - On the following frame_tick: play_en=0, go to IDLE.
    - FIFO contents are retained.
- start while not in IDLE is ignored. stop in IDLE is ignored. stop and start in the same cycle: stop wins.
- Only frame_tick pops; there is at most one pop per frame.
- i2s_bussy is forced to 1 whenever play_en=0, so no tick occurs in IDLE or PRIME.
- underrun_cnt clears only on reset.
- Latency:
  - wr_en to visible in level: 1 cycle.
  - frame_tick to new sample_out: 1 cycle after the tick is detected, 3–4 CLK cycles after the bussy edge.

Test Plan:
- Reset: hold reset=0 for 3 cycles while driving wr_en and start -> level=0, play_en=0, sample_out=0, underrun_cnt=0, state_o=00.
- Fill and wrap:
  - Write 20 frames 0x00010001..0x00140014 with DEPTH=16 -> full=1 after the 16th; frames 17–20 are dropped.
  - Pop 16 times, then write 4 more -> order is preserved across the pointer wrap.
- Prime and play:
  - Write 8 frames A0..A7, then pulse start -> play_en=1 in the same cycle level reaches 8, with sample_out=A0.
  - With the transmitter model connected at DIVISOR=63, serial data reproduces A0..A7 in order.
- Underrun:
  - Play 2 frames, then stop writing -> after the FIFO empties, each frame outputs 0x00000000 and underrun_cnt increments by one per frame.
  - Forced 300 frames with UCNT_W=8 -> underrun_cnt saturates at 255.
- Stop:
  - Pulse stop mid-frame in RUN with 5 frames queued -> the current frame completes, one silent frame follows, then play_en=0 and level=5 (nothing popped after stop).
- Reset mid-RUN: reset=0 during the second half of a frame -> next cycle play_en=0, level=0, state IDLE; a subsequent start with a refilled FIFO plays normally.
